// File: rtl/pwm_level_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_level_pkg
//  Description : Shared types, constants and the ordering check used by the
//                trigger-level controller and its per-level ramp slices.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_level_pkg;

    // Controller state: IDLE accepts writes, RAMP slews outputs to targets.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    // Write-select encoding for wr_addr.
    localparam logic ADDR_VIL = 1'b0;
    localparam logic ADDR_VIH = 1'b1;

    // Power-up thresholds.
    localparam logic [7:0] VIL_RST_DEFAULT = 8'h40;
    localparam logic [7:0] VIH_RST_DEFAULT = 8'hC0;

    // True when lo + min_gap <= hi. Evaluated in 9 bits so a low value near
    // 8'hFF cannot wrap around and falsely pass.
    function automatic logic gap_ok(
        input logic [7:0] lo,
        input logic [7:0] hi,
        input logic [7:0] min_gap
    );
        return ({1'b0, lo} + {1'b0, min_gap}) <= {1'b0, hi};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_level_ctrl_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : level_ramp
//  Description : One threshold slice. Holds a target and a slewed output
//                level; on each boundary strobe the level moves toward the
//                target by at most STEP LSBs.
//  Ports       : clk, rst       - clock, async active-high reset
//                load/load_data - capture a new target
//                bnd            - PWM period boundary strobe
//                level          - current duty value
//                target         - current target
//                at_target      - level equals target
//  Revision    : 1.0 - initial release
// ============================================================================
module level_ramp #(
    parameter int         STEP    = 4,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       bnd,
    output logic [7:0] level,
    output logic [7:0] target,
    output logic       at_target
);

    localparam logic [8:0] c_step = 9'(STEP);

    logic [7:0] r_tgt;
    logic [7:0] r_level;
    logic       w_up;
    logic [8:0] w_dist;
    logic [8:0] w_move;
    logic [8:0] w_next9;
    logic [7:0] w_level_nxt;

    // Step size is min(STEP, distance), so the level lands exactly on the
    // target instead of overshooting it.
    always_comb begin
        w_up    = (r_tgt > r_level);
        w_dist  = w_up ? ({1'b0, r_tgt} - {1'b0, r_level})
                       : ({1'b0, r_level} - {1'b0, r_tgt});
        w_move  = (w_dist < c_step) ? w_dist : c_step;
        w_next9 = w_up ? ({1'b0, r_level} + w_move)
                       : ({1'b0, r_level} - w_move);
        // Bit 8 can only be set by an out-of-range result; saturate rather
        // than wrap so the duty value never jumps across the full scale.
        if (w_next9[8]) begin
            w_level_nxt = w_up ? 8'hFF : 8'h00;
        end else begin
            w_level_nxt = w_next9[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tgt   <= RST_VAL;
            r_level <= RST_VAL;
        end else begin
            if (load) begin
                r_tgt <= load_data;
            end
            // The update uses the target as it stood before any same-cycle
            // load, so a write on a boundary waits for the next one.
            if (bnd) begin
                r_level <= w_level_nxt;
            end
        end
    end

    assign level     = r_level;
    assign target    = r_tgt;
    assign at_target = (r_level == r_tgt);

endmodule
`default_nettype wire

// File: rtl/pwm_level_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_level_ctrl
//  Description : VIL/VIH threshold controller for the dual 8-bit PWM. Accepts
//                target writes that keep VIH - VIL >= MIN_GAP, then slews the
//                duty outputs toward the targets at PWM period boundaries.
//  Ports       : clk, rst          - clock, async active-high reset
//                wr_en/wr_addr/
//                wr_data           - write request (addr 0 = VIL, 1 = VIH)
//                wr_rdy            - write can be accepted (IDLE)
//                err               - one-cycle pulse on a rejected write
//                VIL, VIH          - duty values to the dual PWM
//                settled           - outputs equal their targets
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_level_ctrl
    import pwm_level_pkg::*;
#(
    parameter int         PERIOD_W = 8,
    parameter int         STEP     = 4,
    parameter int         MIN_GAP  = 8,
    parameter logic [7:0] VIL_RST  = VIL_RST_DEFAULT,
    parameter logic [7:0] VIH_RST  = VIH_RST_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_rdy,
    output logic       err,
    output logic [7:0] VIL,
    output logic [7:0] VIH,
    output logic       settled
);

    localparam logic [7:0] c_min_gap = 8'(MIN_GAP);

    logic [PERIOD_W-1:0] r_cnt;
    logic                w_bnd;
    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_err;

    logic                w_accept;
    logic                w_sel_vil;
    logic                w_legal;
    logic [7:0]          w_cur;
    logic                w_load_vil;
    logic                w_load_vih;
    logic [7:0]          w_tgt_vil;
    logic [7:0]          w_tgt_vih;
    logic                w_vil_at;
    logic                w_vih_at;

    // Free-running period counter; the all-ones count marks the last clock
    // of a PWM period, so registered updates appear at count 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_bnd = &r_cnt;

    // Write qualification and ordering check against the other target.
    always_comb begin
        w_accept   = wr_en && wr_rdy;
        w_sel_vil  = (wr_addr == ADDR_VIL);
        w_legal    = w_sel_vil ? gap_ok(wr_data, w_tgt_vih, c_min_gap)
                               : gap_ok(w_tgt_vil, wr_data, c_min_gap);
        w_cur      = w_sel_vil ? VIL : VIH;
        w_load_vil = w_accept && w_legal && w_sel_vil;
        w_load_vih = w_accept && w_legal && (wr_addr == ADDR_VIH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && !w_legal;
        end
    end

    assign err = r_err;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. Writes equal to the present output leave nothing to
    // slew, so they stay in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_legal && (wr_data != w_cur)) begin
                    w_state_nxt = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (w_vil_at && w_vih_at) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic. Blocking writes during RAMP guarantees only one target
    // moves per ramp, which keeps the outputs ordered while slewing.
    always_comb begin
        wr_rdy  = 1'b0;
        settled = 1'b0;
        if (r_state == ST_IDLE) begin
            wr_rdy  = 1'b1;
            settled = 1'b1;
        end
    end

    level_ramp #(
        .STEP    (STEP),
        .RST_VAL (VIL_RST)
    ) u_ramp_vil (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load_vil),
        .load_data (wr_data),
        .bnd       (w_bnd),
        .level     (VIL),
        .target    (w_tgt_vil),
        .at_target (w_vil_at)
    );

    level_ramp #(
        .STEP    (STEP),
        .RST_VAL (VIH_RST)
    ) u_ramp_vih (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load_vih),
        .load_data (wr_data),
        .bnd       (w_bnd),
        .level     (VIH),
        .target    (w_tgt_vih),
        .at_target (w_vih_at)
    );

endmodule
`default_nettype wire

// File: doc/pwm_level_ctrl.md
Name: pwm_level_ctrl

Overview:
Upstream stage of the dual 8-bit trigger-level PWM. Holds the VIL/VIH threshold targets written by the command interface and enforces the ordering rule VIH - VIL >= MIN_GAP. It drives the VIL/VIH duty values into the dual PWM, slewing each value toward its target only at PWM-period boundaries. This keeps the duty values glitch-free and keeps the filtered comparator references ordered at all times.

Parameters:
PERIOD_W, 8, width of the free-running period counter; a boundary occurs every 2^PERIOD_W clocks, which matches the 256-clock PWM period
STEP, 4, maximum change of each level per boundary, in LSBs
MIN_GAP, 8, minimum allowed VIH - VIL separation, in LSBs
VIL_RST, 8'h40, reset value of the VIL target and output
VIH_RST, 8'hC0, reset value of the VIH target and output

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
wr_en  input  1  write request, qualified by wr_rdy
wr_addr  input  1  write select: 0 = VIL, 1 = VIH
wr_data  input  8  requested level
wr_rdy  output  1  high when a write can be accepted (IDLE state)
err  output  1  one-cycle pulse when an accepted write is rejected for a gap violation
VIL  output  8  VIL duty value driven to the dual PWM
VIH  output  8  VIH duty value driven to the dual PWM
settled  output  1  high when both outputs equal their targets

Behaviour:
- Reset (asynchronous, rst=1):
  - tgt_VIL = VIL = VIL_RST; tgt_VIH = VIH = VIH_RST.
  - Period counter = 0; state = IDLE; wr_rdy = 1; settled = 1; err = 0.
  - Assertion in any state, including mid-ramp, discards the ramp and restores these values immediately.
- Period counter: free-running, PERIOD_W bits, increments every clock and wraps from all-ones to 0.
  - Boundary strobe bnd = (count == all-ones); one cycle in every 2^PERIOD_W.
- Write acceptance: a write is accepted when wr_en && wr_rdy.
- Gap check: combinational, 9-bit unsigned arithmetic.
  - VIL write legal iff wr_data + MIN_GAP <= tgt_VIH.
  - VIH write legal iff tgt_VIL + MIN_GAP <= wr_data.
- Illegal write: err = 1 in the next cycle for exactly one cycle; targets and state unchanged.
- Legal write: the selected target register takes wr_data in the next cycle.
  - If wr_data differs from the current output, state -> RAMP.
  - Otherwise the write is a no-op and state stays IDLE.
- States:
  - IDLE: wr_rdy = 1, settled = 1.
  - RAMP: wr_rdy = 0, settled = 0. wr_en is ignored (no capture, no err).
- RAMP update, on each bnd cycle only: each output moves toward its target by min(STEP, |target - output|).
  - Computed in 9 bits, so no overflow or underflow occurs at 8'h00 or 8'hFF.
  - The new output values are registered on the bnd edge, so they are first valid at count = 0, the start of the next PWM period.
  - RAMP -> IDLE in the cycle after the update that makes both outputs equal their targets.
- Ordering invariant: only one target can change per ramp, because writes are blocked in RAMP. Monotonic slew toward a legal target therefore keeps VIH - VIL >= MIN_GAP on every cycle. The bench asserts this continuously.
- Latency:
  - Write accepted on cycle N; target updated on N+1.
  - First output change occurs on the first bnd strictly after N.
  - A write accepted on a bnd cycle waits for the following boundary.
- Outputs change only on bnd edges, except under reset.

Decomposition:
- Package pwm_level_pkg:
  - state enum {IDLE, RAMP}
  - ADDR_VIL / ADDR_VIH constants
  - default VIL_RST / VIH_RST
  - gap-check function
- Sub-module level_ramp, instantiated twice (VIL, VIH):
  - holds one target/output pair
  - inputs: load, load_data, bnd
  - outputs: level, at_target
- Parent owns the period counter, gap check, FSM and err.

Test Plan:
- Reset → VIL = 8'h40, VIH = 8'hC0, settled = 1, wr_rdy = 1, err = 0. Release reset, hold 600 clocks → outputs unchanged.
- Write VIL = 8'h50 → VIL steps 44, 48, 4C, 50 at successive boundaries; wr_rdy low throughout; settled rises one cycle after the 8'h50 update.
- Write VIL = 8'h42 from 8'h40 → a single clamped step to 8'h42, no overshoot. Then write VIH = 8'h48 → err pulses for one cycle and VIH stays 8'hC0. Write VIH = 8'h4A → accepted.
- Write VIH = 8'hFF, then VIL = 8'h00 → saturating steps with no wrap; final values 8'hFF and 8'h00. Pulse wr_en in RAMP with 8'h10 → ignored, err stays 0.
- Assert rst mid-ramp (VIL = 8'h48, target 8'h50) → immediate return to 8'h40/8'hC0 and IDLE. Write VIL = 8'h44 on a bnd cycle → change appears at the next boundary, 256 clocks later.
